// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin on contention, ownership held while the owner's cyc is high.
// Define WB_ARB_TIMEOUT_EN to add the stalled-transfer abort (TIMEOUT_CYCLES) and the sticky timeout_o flag.
module wb_master_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] ABORT_DATA = 32'hDEAD_BEEF;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_master_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    // State encoding doubles as the one-hot grant vector {OWN1, OWN0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt;      // 0: m0 granted most recently, 1: m1
    logic   last_gnt_nxt;
    logic   req0;
    logic   req1;
    logic   to_fire;       // timeout abort is due in this cycle

    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;
    assign gnt_o = state;

    // Next state, last-grant tracking and the combinational bus steering.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        s_sel_o      = '0;
        m0_ack_o     = 1'b0;
        m0_dat_o     = '0;
        m1_ack_o     = 1'b0;
        m1_dat_o     = '0;

        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_gnt)) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_nxt = req1 ? OWN1 : IDLE;
                end
                s_cyc_o  = m0_cyc_i & ~to_fire;
                s_stb_o  = m0_stb_i & ~to_fire;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = m0_cyc_i & (s_ack_i | to_fire);
                m0_dat_o = (to_fire && !s_ack_i) ? ABORT_DATA : s_dat_i;
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_nxt = req0 ? OWN0 : IDLE;
                end
                s_cyc_o  = m1_cyc_i & ~to_fire;
                s_stb_o  = m1_stb_i & ~to_fire;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = m1_cyc_i & (s_ack_i | to_fire);
                m1_dat_o = (to_fire && !s_ack_i) ? ABORT_DATA : s_dat_i;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) begin
            if (state_nxt == OWN0) begin
                last_gnt_nxt = 1'b0;
            end else if (state_nxt == OWN1) begin
                last_gnt_nxt = 1'b1;
            end
        end
    end

    // Reset leaves last_gnt at m1 so m0 wins the first contention.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] stall_cnt;
    logic          timeout_q;
    logic          owner_cyc;
    logic          abort_c;

    assign owner_cyc = ((state == OWN0) && m0_cyc_i) || ((state == OWN1) && m1_cyc_i);
    // A coinciding slave ack wins over the synthetic abort.
    assign abort_c   = to_fire & owner_cyc & ~s_ack_i;
    assign timeout_o = timeout_q;

    // Stall counter: advances on unacknowledged strobes, holds across stb gaps.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            stall_cnt <= '0;
            to_fire   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (abort_c) begin
                timeout_q <= 1'b1;
            end
            if (state == IDLE || state_nxt != state || s_ack_i) begin
                stall_cnt <= '0;
                to_fire   <= 1'b0;
            end else if (s_stb_o) begin
                if (stall_cnt == CNT_LAST) begin
                    stall_cnt <= '0;
                    to_fire   <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + CW'(1);
                    to_fire   <= 1'b0;
                end
            end else begin
                to_fire <= 1'b0;
            end
        end
    end
`else
    assign to_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomized and directed bench for wb_master_arbiter against a transaction-level ownership model.
// Timeout scenarios run when WB_ARB_TIMEOUT_EN is defined; otherwise the no-timeout behaviour is checked.
module tb_wb_master_arbiter;

    localparam int unsigned TO = 8;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cyc = '0;
    logic [1:0]  stb = '0;
    logic [1:0]  we = '0;
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic [31:0] s_rdat = '0;
    logic        s_ack = 1'b0;
    logic [1:0]  gnt;
    logic        tmo;

    // Reference model: current owner (-1 = nobody), last winner, stall run length.
    int own, last, run;
    bit hit_m, to_m;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),     .wb_rst_n (rst_n),
        .m0_cyc_i (cyc[0]),  .m0_stb_i (stb[0]),  .m0_we_i (we[0]),
        .m0_adr_i (adr[0]),  .m0_dat_i (wdat[0]), .m0_sel_i (sel[0]),
        .m0_dat_o (m0_rdat), .m0_ack_o (m0_ack),
        .m1_cyc_i (cyc[1]),  .m1_stb_i (stb[1]),  .m1_we_i (we[1]),
        .m1_adr_i (adr[1]),  .m1_dat_i (wdat[1]), .m1_sel_i (sel[1]),
        .m1_dat_o (m1_rdat), .m1_ack_o (m1_ack),
        .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),   .s_we_o  (s_we),
        .s_adr_o  (s_adr),   .s_dat_o  (s_wdat),  .s_sel_o (s_sel),
        .s_dat_i  (s_rdat),  .s_ack_i  (s_ack),
        .gnt_o    (gnt),     .timeout_o (tmo)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; run = 0; hit_m = 1'b0; to_m = 1'b0;
    endtask

    task automatic drive(input int m, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        cyc[m] = c; stb[m] = s; we[m] = w; adr[m] = a; wdat[m] = d; sel[m] = 4'hF;
    endtask

    task automatic slave(input logic a, input logic [31:0] d);
        s_ack = a; s_rdat = d;
    endtask

    // Expected bus view from the model's owner.
    task automatic check_outputs();
        logic [6:0]  e_ctl;
        logic [31:0] e_adr, e_wd;
        logic [32:0] e_m [2];
        e_ctl = '0; e_adr = '0; e_wd = '0; e_m[0] = '0; e_m[1] = '0;
        if (own >= 0) begin
            e_ctl = {cyc[own] & ~hit_m, stb[own] & ~hit_m, we[own], sel[own]};
            e_adr = adr[own];
            e_wd  = wdat[own];
            e_m[own] = {cyc[own] & (s_ack | hit_m), (hit_m && !s_ack) ? DEAD : s_rdat};
        end
        check("gnt", gnt, (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00);
        check("s_ctl", {s_cyc, s_stb, s_we, s_sel}, e_ctl);
        check("s_adr", s_adr, e_adr);
        check("s_dat", s_wdat, e_wd);
        check("m0_rsp", {m0_ack, m0_rdat}, e_m[0]);
        check("m1_rsp", {m1_ack, m1_rdat}, e_m[1]);
        check("timeout", tmo, to_m);
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step();
        int nxt;
        bit req [2];
        bit stall;
        req[0] = cyc[0] & stb[0];
        req[1] = cyc[1] & stb[1];
        nxt = own;
        if (own < 0) begin
            if (req[0] && req[1]) nxt = (last == 1) ? 0 : 1;
            else if (req[0])      nxt = 0;
            else if (req[1])      nxt = 1;
        end else if (!cyc[own]) begin
            nxt = req[1 - own] ? 1 - own : -1;
        end
        if (own >= 0 && hit_m && cyc[own] && !s_ack) to_m = 1'b1;
        stall = (own >= 0) && (nxt == own) && stb[own] && !hit_m && !s_ack;
        if (!TO_EN || own < 0 || nxt != own || s_ack) begin
            run = 0; hit_m = 1'b0;
        end else if (stall) begin
            run++;
            hit_m = (run == TO);
            if (hit_m) run = 0;
        end else begin
            hit_m = 1'b0;
        end
        if (nxt >= 0 && nxt != own) last = nxt;
        own = nxt;
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        slave(0, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_tmo", tmo, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0; sel[0] = '0; sel[1] = '0;

        // Single read by m0 with a two-cycle wait state.
        do_reset();
        drive(0, 1, 1, 0, 32'h3000_0004, 32'h0);
        cycle();
        #1 check("rd_gnt", gnt, 2'b01);
        check("rd_adr", s_adr, 32'h3000_0004);
        cycle();
        cycle();
        slave(1, 32'h1234_5678);
        #1 check("rd_ack", m0_ack, 1'b1);
        check("rd_dat", m0_rdat, 32'h1234_5678);
        cycle();
        slave(0, '0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("rd_gnt_hold", gnt, 2'b01);
        check("rd_scyc_drop", s_cyc, 1'b0);
        cycle();
        #1 check("rd_gnt_release", gnt, 2'b00);
        cycle();

        // Contention out of reset, direct handover, then a repeat contention.
        do_reset();
        drive(0, 1, 1, 0, 32'h3000_0100, 32'h0);
        drive(1, 1, 1, 1, 32'h3000_0200, 32'hA5A5_0001);
        cycle();
        #1 check("rr_first", gnt, 2'b01);
        slave(1, 32'h0000_00AA);
        cycle();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        slave(0, '0);
        #1 check("rr_hold0", gnt, 2'b01);
        check("rr_m1_wait", m1_ack, 1'b0);
        cycle();
        #1 check("rr_handover", gnt, 2'b10);
        slave(1, '0);
        cycle();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        slave(0, '0);
        cycle();
        #1 check("rr_idle", gnt, 2'b00);
        drive(0, 1, 1, 0, 32'h3000_0300, 32'h0);
        drive(1, 1, 1, 0, 32'h3000_0400, 32'h0);
        cycle();
        #1 check("rr_repeat", gnt, 2'b01);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        cycle();

        // m1 locks the bus across four writes with strobe gaps.
        do_reset();
        drive(1, 1, 1, 1, 32'h3000_1000, 32'h1111_0000);
        cycle();
        drive(0, 1, 1, 0, 32'h3000_2000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 1, 32'h3000_1000 + 32'(4 * k), 32'h1111_0000 + 32'(k));
            slave(1, 32'h0BAD_0000 + 32'(k));
            #1 check("lk_gnt", gnt, 2'b10);
            check("lk_m0_ack", m0_ack, 1'b0);
            check("lk_m0_dat", m0_rdat, 32'h0);
            cycle();
            stb[1] = 1'b0;
            slave(0, '0);
            #1 check("lk_gap_gnt", gnt, 2'b10);
            cycle();
        end
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        #1 check("lk_last_gnt", gnt, 2'b10);
        cycle();
        #1 check("lk_handover", gnt, 2'b01);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        cycle();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never answers: abort on the ninth stall cycle.
        do_reset();
        drive(0, 1, 1, 0, 32'h3000_0010, 32'h0);
        cycle();
        for (int k = 1; k <= 8; k++) begin
            #1 check("to_stall_ack", m0_ack, 1'b0);
            cycle();
        end
        #1 check("to_ack", m0_ack, 1'b1);
        check("to_dat", m0_rdat, DEAD);
        check("to_scyc", s_cyc, 1'b0);
        check("to_flag_pre", tmo, 1'b0);
        cycle();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("to_flag", tmo, 1'b1);
        check("to_ack_once", m0_ack, 1'b0);
        cycle();
        cycle();
        #1 check("to_sticky", tmo, 1'b1);

        // Slave ack lands on the abort cycle: real data wins.
        do_reset();
        drive(0, 1, 1, 0, 32'h3000_0014, 32'h0);
        cycle();
        for (int k = 1; k <= 8; k++) cycle();
        slave(1, 32'hCAFE_F00D);
        #1 check("to_race_ack", m0_ack, 1'b1);
        check("to_race_dat", m0_rdat, 32'hCAFE_F00D);
        cycle();
        slave(0, '0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("to_race_flag", tmo, 1'b0);
        cycle();
`else
        // Without the timeout the arbiter waits for the slave indefinitely.
        do_reset();
        drive(0, 1, 1, 0, 32'h3000_0010, 32'h0);
        cycle();
        for (int k = 0; k < 300; k++) cycle();
        #1 check("nto_ack", m0_ack, 1'b0);
        check("nto_gnt", gnt, 2'b01);
        check("nto_flag", tmo, 1'b0);
        slave(1, 32'h7777_0001);
        cycle();
        slave(0, '0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
`endif

        // Asynchronous reset in the middle of an acknowledged transfer.
        do_reset();
        drive(0, 1, 1, 0, 32'h3000_0020, 32'h0);
        cycle();
        slave(1, 32'h5555_AAAA);
        #1 check("ar_pre_ack", m0_ack, 1'b1);
        check("ar_pre_gnt", gnt, 2'b01);
        #1 rst_n = 1'b0;
        #1 check("ar_scyc", s_cyc, 1'b0);
        check("ar_ack0", m0_ack, 1'b0);
        check("ar_ack1", m1_ack, 1'b0);
        check("ar_gnt", gnt, 2'b00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        slave(0, '0);
        rst_n = 1'b1;
        cycle();
        #1 check("ar_resume", gnt, 2'b01);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        cycle();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 4) == 0) cyc[m] = ~cyc[m];
                stb[m]  = cyc[m] & ($urandom_range(0, 3) != 0);
                we[m]   = 1'($urandom);
                adr[m]  = $urandom;
                wdat[m] = $urandom;
                sel[m]  = 4'($urandom);
            end
            slave($urandom_range(0, 2) == 0, $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, which sets the stalled-transfer limit in clocks (range 2..65535).
REQ-002 The module SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port wb_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port group m0_cyc_i / m0_stb_i / m0_we_i, input, 1 bit each: master 0 (Caravel management Wishbone) cycle, strobe and write.
REQ-005 The module SHALL have port group m0_adr_i and m0_dat_i, input, 32 bits each, and m0_sel_i, input, 4 bits: master 0 address, write data and byte selects.
REQ-006 The module SHALL have port m0_dat_o, output, 32 bits, and m0_ack_o, output, 1 bit: master 0 read data and acknowledge.
REQ-007 The module SHALL have ports m1_*, identical in direction and width to REQ-004..006: master 1, the logic-analyzer-driven master.
REQ-008 The module SHALL have port group s_cyc_o / s_stb_o / s_we_o, output, 1 bit each; s_adr_o and s_dat_o, output, 32 bits each; s_sel_o, output, 4 bits: the shared slave port toward the user macro.
REQ-009 The module SHALL have port s_dat_i, input, 32 bits, and s_ack_i, input, 1 bit: slave read data and acknowledge.
REQ-010 The module SHALL have port gnt_o, output, 2 bits: one-hot registered owner, where bit0 means m0 and bit1 means m1.
REQ-011 The module SHALL have port timeout_o, output, 1 bit: sticky flag set by a timeout abort.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1; gnt_o SHALL equal {OWN1, OWN0}.
REQ-013 A master SHALL count as requesting when mX_cyc_i & mX_stb_i.
REQ-014 In IDLE, a single requester SHALL be granted on the next edge, giving one-cycle arbitration latency.
REQ-015 In IDLE, if both masters request, the master not in last_gnt SHALL be granted, and last_gnt SHALL update on every grant (round-robin).
REQ-016 In OWNx, s_* SHALL be driven combinationally from master x, with s_cyc_o = mx_cyc_i.
REQ-017 In OWNx, mx_ack_o SHALL equal s_ack_i and mx_dat_o SHALL equal s_dat_i.
REQ-018 In OWNx, the non-owner SHALL see ack_o = 0 and dat_o = 0.
REQ-019 In IDLE, all s_* outputs and both ack_o SHALL be 0, and both dat_o SHALL be 0.
REQ-020 Ownership SHALL persist while the owner's cyc_i is high, including across stb gaps (block/RMW lock).
REQ-021 When the owner's cyc_i falls, the next state SHALL be OWN(other) if the other master is requesting, otherwise IDLE.
REQ-022 An owner dropping cyc_i before ack SHALL abort the transfer: s_cyc_o falls in that same cycle and no ack is delivered.
REQ-023 A requester that drops its request before being granted SHALL NOT be granted.
REQ-024 An ack arriving while the FSM is in IDLE SHALL be ignored.

Reset
REQ-025 While wb_rst_n = 0, regardless of clock, the state SHALL be IDLE, last_gnt SHALL be m1 (so m0 wins the first contention), gnt_o SHALL be 00, timeout_o SHALL be 0 and the timeout counter SHALL be 0.
REQ-026 Assertion of reset mid-transfer SHALL drop s_cyc_o and both ack_o immediately.
REQ-027 Arbitration SHALL resume on the first edge after wb_rst_n rises.

Configuration
REQ-028 With WB_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL increment each cycle in OWNx while s_stb_o & ~s_ack_i, and SHALL clear on s_ack_i or on a state change.
REQ-029 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1, the next cycle SHALL assert the owner's ack_o for exactly 1 cycle with dat_o = 32'hDEAD_BEEF, force s_cyc_o = 0 for that cycle, set timeout_o, and clear the counter.
REQ-030 With WB_ARB_TIMEOUT_EN defined, if s_ack_i coincides with the timeout cycle, the slave ack and data SHALL win and timeout_o SHALL be unchanged.
REQ-031 With WB_ARB_TIMEOUT_EN defined, timeout_o SHALL clear only on reset.
REQ-032 Without WB_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_o SHALL be tied 0, and the arbiter SHALL wait indefinitely for s_ack_i.

Verification
REQ-033 The bench SHALL cover: m0 reads 0x3000_0004, slave acks 2 cycles after s_stb_o with 0x1234_5678 -> m0_dat_o = 0x1234_5678 with m0_ack_o, gnt_o = 01, then 00 one cycle after m0_cyc_i falls.
REQ-034 The bench SHALL cover: m0 and m1 request on the same edge out of reset -> gnt_o = 01 first; after m0 releases with m1 still requesting -> gnt_o = 10 with no IDLE cycle; a repeat contention -> m0 granted.
REQ-035 The bench SHALL cover: m1 holds cyc_i for 4 writes with stb_i gaps while m0 requests -> m0 stays ungranted and sees ack 0 until m1 cyc_i falls.
REQ-036 The bench SHALL cover (TIMEOUT_EN, TIMEOUT_CYCLES = 8): slave never acks -> m0_ack_o pulses once with 0xDEAD_BEEF on the 9th stall cycle and timeout_o = 1 thereafter; a slave ack on that same cycle -> real data returned and timeout_o = 0.
REQ-037 The bench SHALL cover: wb_rst_n pulled low mid-transfer between clock edges -> s_cyc_o, acks and gnt_o read 0 immediately, before the next clock edge.
